// File: rtl/fire7_expand1_ofm_writer.sv
// fire7_expand1_ofm_writer: holds one ofm vector per pixel and streams it into LANES banks in channel-planar order
module fire7_expand1_ofm_writer #(
    parameter int DSP_NO = 192,
    parameter int WIDTH = 16,
    parameter int WOUT = 16,
    parameter int LANES = 4,
    localparam int BEATS = DSP_NO / LANES,
    localparam int NPIX = WOUT * WOUT,
    localparam int AW = $clog2(BEATS * NPIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire7_expand1_sample,
    input  logic [WIDTH-1:0] ofm [0:DSP_NO-1],
    input  logic             fire7_expand1_finish,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_wdata [0:LANES-1],
    output logic             ram_feedback,
    output logic             busy,
    output logic             overrun
);
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW = $clog2(NPIX + 1);
    localparam int CW = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    typedef enum logic [1:0] {IDLE, WRITE, WAIT_FIN, DONE} state_t;
    state_t r_state, w_state_nxt;
    logic [BW-1:0] r_beat, w_beat_nxt;
    logic [PW-1:0] r_pix, w_pix_nxt, w_pix_inc;
    logic r_overrun, w_overrun_nxt, w_cap, w_last;
    logic [WIDTH-1:0] r_buf [0:DSP_NO-1];
    assign w_pix_inc = r_pix + 1'b1;
    assign w_last = r_beat == BW'(BEATS - 1);
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_beat <= '0;
            r_pix <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat <= w_beat_nxt;
            r_pix <= w_pix_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (w_cap) r_buf <= ofm;
    end
    // samples landing while a vector is still draining are dropped and flagged
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt = r_beat;
        w_pix_nxt = r_pix;
        w_overrun_nxt = r_overrun;
        w_cap = 1'b0;
        ram_feedback = 1'b0;
        case (r_state)
            IDLE: begin
                w_cap = fire7_expand1_sample;
                w_state_nxt = fire7_expand1_sample ? WRITE : IDLE;
            end
            WRITE: begin
                w_overrun_nxt = r_overrun | fire7_expand1_sample;
                w_beat_nxt = w_last ? '0 : r_beat + 1'b1;
                w_pix_nxt = w_last ? w_pix_inc : r_pix;
                if (w_last) w_state_nxt = (w_pix_inc == PW'(NPIX)) ? WAIT_FIN : IDLE;
            end
            WAIT_FIN: begin
                ram_feedback = fire7_expand1_finish;
                w_state_nxt = fire7_expand1_finish ? DONE : WAIT_FIN;
            end
            default: ;
        endcase
    end
    assign ram_we = r_state == WRITE;
    assign busy = r_state == WRITE;
    assign overrun = r_overrun;
    assign ram_addr = AW'(r_beat) * AW'(NPIX) + AW'(r_pix);
    for (genvar b = 0; b < LANES; b++) begin : g_lane
        assign ram_wdata[b] = r_buf[CW'(r_beat) * CW'(LANES) + CW'(b)];
    end
endmodule

// File: tb/tb_fire7_expand1_ofm_writer.sv
// tb_fire7_expand1_ofm_writer: table-driven and sequence checks with a write scoreboard
module tb_fire7_expand1_ofm_writer;
    localparam int DSP_NO = 192;
    localparam int WIDTH = 16;
    localparam int WOUT = 16;
    localparam int LANES = 4;
    localparam int BEATS = DSP_NO / LANES;
    localparam int NPIX = WOUT * WOUT;
    localparam int AW = $clog2(BEATS * NPIX);
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sample = 1'b0;
    logic finish = 1'b0;
    logic [WIDTH-1:0] ofm [0:DSP_NO-1];
    logic ram_we, ram_feedback, busy, overrun;
    logic [AW-1:0] ram_addr;
    logic [WIDTH-1:0] ram_wdata [0:LANES-1];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LANES*WIDTH-1:0] data;
    } wr_t;
    typedef struct {
        logic [15:0] seed;
        logic [15:0] mul;
        int gap;
        int exp_wr;
        logic exp_ovr;
    } row_t;
    wr_t q[$];
    wr_t mon_e;
    logic [LANES*WIDTH-1:0] mon_d;
    logic [AW-1:0] last_addr;
    logic [WIDTH-1:0] last_lane3;
    int n_chk = 0, n_fail = 0, cyc = 0, n_wr = 0, n_busy = 0, n_fb = 0;
    int last_wr_cyc = -1, fb_cyc = -1, exp_pix = 0;
    fire7_expand1_ofm_writer dut (
        .clk(clk),
        .rst(rst),
        .fire7_expand1_sample(sample),
        .ofm(ofm),
        .fire7_expand1_finish(finish),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_feedback(ram_feedback),
        .busy(busy),
        .overrun(overrun)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (busy === 1'b1) n_busy++;
        if (ram_feedback === 1'b1) begin
            n_fb++;
            fb_cyc = cyc;
        end
        if (ram_we === 1'b1) begin
            for (int b = 0; b < LANES; b++) mon_d[b*WIDTH +: WIDTH] = ram_wdata[b];
            n_wr++;
            last_wr_cyc = cyc;
            last_addr = ram_addr;
            last_lane3 = ram_wdata[3];
            chk("sb_nonempty", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("wr_addr", 64'(ram_addr), 64'(mon_e.addr));
                chk("wr_data", 64'(mon_d), 64'(mon_e.data));
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b0;
        sample = 1'b0;
        finish = 1'b0;
        tick();
        chk("rst_we", 64'(ram_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fb", 64'(ram_feedback), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        tick();
        rst = 1'b1;
        q.delete();
        exp_pix = 0;
        n_wr = 0;
        n_busy = 0;
        n_fb = 0;
    endtask
    task automatic set_vec(input logic [15:0] seed, input logic [15:0] mul);
        for (int c = 0; c < DSP_NO; c++) ofm[c] = seed + 16'(c) * mul;
    endtask
    task automatic push_exp();
        wr_t e;
        for (int k = 0; k < BEATS; k++) begin
            e.addr = AW'(k * NPIX + exp_pix);
            for (int b = 0; b < LANES; b++) e.data[b*WIDTH +: WIDTH] = ofm[k*LANES + b];
            q.push_back(e);
        end
        exp_pix++;
    endtask
    task automatic pulse(input logic expect_write);
        sample = 1'b1;
        if (expect_write) push_exp();
        tick();
        sample = 1'b0;
    endtask
    initial begin
        row_t rows [6];
        logic [15:0] exp_last;
        rows[0] = '{16'h0000, 16'h0001, 0, 48, 1'b0};
        rows[1] = '{16'hFFFF, 16'hFFFF, 0, 48, 1'b0};
        rows[2] = '{16'h8000, 16'h0003, 10, 48, 1'b1};
        rows[3] = '{16'h1234, 16'h0005, 1, 48, 1'b1};
        rows[4] = '{16'hABCD, 16'h0007, 48, 48, 1'b1};
        rows[5] = '{16'h0F0F, 16'h000B, 49, 96, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            set_vec(rows[i].seed, rows[i].mul);
            pulse(1'b1);
            if (rows[i].gap > 0) begin
                repeat (rows[i].gap - 1) tick();
                set_vec(~rows[i].seed, rows[i].mul + 16'd1);
                pulse(!rows[i].exp_ovr);
            end
            repeat (120) tick();
            chk($sformatf("row%0d_writes", i), 64'(n_wr), 64'(rows[i].exp_wr));
            chk($sformatf("row%0d_busy", i), 64'(n_busy), 64'(rows[i].exp_wr));
            chk($sformatf("row%0d_overrun", i), 64'(overrun), 64'(rows[i].exp_ovr));
            chk($sformatf("row%0d_pending", i), 64'(q.size()), 64'd0);
        end
        do_reset();
        set_vec(16'h4321, 16'h0011);
        pulse(1'b1);
        repeat (20) tick();
        rst = 1'b0;
        tick();
        chk("midrst_we", 64'(ram_we), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_fb", 64'(ram_feedback), 64'd0);
        chk("midrst_overrun", 64'(overrun), 64'd0);
        chk("midrst_writes", 64'(n_wr), 64'd21);
        q.delete();
        tick();
        rst = 1'b1;
        exp_pix = 0;
        n_wr = 0;
        tick();
        chk("midrst_release_writes", 64'(n_wr), 64'd0);
        set_vec(16'h0777, 16'h0101);
        pulse(1'b1);
        repeat (60) tick();
        chk("midrst_rewrite_writes", 64'(n_wr), 64'd48);
        chk("midrst_rewrite_pending", 64'(q.size()), 64'd0);
        do_reset();
        for (int p = 0; p < NPIX; p++) begin
            set_vec(16'(p * 257), 16'(p | 1));
            pulse(1'b1);
            if (p == 99) finish = 1'b1;
            repeat (64) tick();
            if (p == NPIX - 2) chk("early_finish_no_fb", 64'(n_fb), 64'd0);
        end
        exp_last = 16'(255 * 257) + 16'(191) * 16'(255);
        chk("layer_writes", 64'(n_wr), 64'd12288);
        chk("layer_fb_count", 64'(n_fb), 64'd1);
        chk("layer_fb_timing", 64'(fb_cyc), 64'(last_wr_cyc + 1));
        chk("layer_overrun", 64'(overrun), 64'd0);
        chk("layer_last_addr", 64'(last_addr), 64'd12287);
        chk("layer_last_lane3", 64'(last_lane3), 64'(exp_last));
        chk("layer_pending", 64'(q.size()), 64'd0);
        set_vec(16'hDEAD, 16'h0001);
        pulse(1'b0);
        repeat (60) tick();
        chk("surplus_writes", 64'(n_wr), 64'd12288);
        chk("surplus_overrun", 64'(overrun), 64'd0);
        chk("surplus_fb_count", 64'(n_fb), 64'd1);
        chk("surplus_busy", 64'(busy), 64'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
